// File: rtl/framebuffer_dbl.sv
// Ping-pong frame store for the DM633 LED chain: the writer fills the back buffer,
// the shifter reads the front buffer, and swaps wait until the reader is between frames.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | normal operation; swaps at once when the reader is idle
// ST_CLEAR     | clear engine writes c_clear_val to back[0..c_channels-1]
// ST_SWAP_WAIT | swap requested while the reader is mid-frame; waiting
module framebuffer_dbl #(
  parameter int              c_ledboards = 30,
  parameter int              c_channels  = c_ledboards * 32,
  parameter int              c_addr_w    = $clog2(c_channels),
  parameter int              c_bps       = 12,
  parameter logic [c_bps-1:0] c_clear_val = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wen,
  input  logic [c_addr_w-1:0] i_waddr,
  input  logic [c_bps-1:0]    i_wdata,
  input  logic                i_ren,
  input  logic [c_addr_w-1:0] i_raddr,
  output logic [c_bps-1:0]    o_rdata,
  output logic                o_rvalid,
  input  logic                i_swap_req,
  input  logic                i_rd_busy,
  output logic                o_swap_done,
  output logic                o_front_sel,
  input  logic                i_clear,
  output logic                o_clear_busy
);

  localparam int                 c_idx_w    = $clog2(c_channels);
  localparam logic [c_addr_w:0]  c_chan_ext = (c_addr_w + 1)'(c_channels);
  localparam logic [c_addr_w-1:0] c_last    = c_addr_w'(c_channels - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_t;

  state_t              state_q;
  logic                front_sel_q;
  logic                swap_done_q;
  logic                clear_busy_q;
  logic                pending_q;
  logic [c_addr_w-1:0] cnt_q;
  logic [c_bps-1:0]    rdata_q;
  logic                rvalid_q;

  logic [c_bps-1:0]    mem0_q [c_channels];
  logic [c_bps-1:0]    mem1_q [c_channels];

  logic                wr_en;
  logic [c_idx_w-1:0]  wr_addr;
  logic [c_bps-1:0]    wr_data;
  logic                waddr_ok;
  logic                raddr_ok;
  logic [c_idx_w-1:0]  rd_idx;

  assign waddr_ok = ({1'b0, i_waddr} < c_chan_ext);
  assign raddr_ok = ({1'b0, i_raddr} < c_chan_ext);
  assign rd_idx   = i_raddr[c_idx_w-1:0];

  // Single back-buffer write port shared by the clear engine and the writer.
  // Gated by reset so a reset edge that aborts a clear writes nothing.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = c_clear_val;
    if (i_rst_n) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt_q[c_idx_w-1:0];
      end else if (i_wen && !clear_busy_q && waddr_ok) begin
        wr_en   = 1'b1;
        wr_addr = i_waddr[c_idx_w-1:0];
        wr_data = i_wdata;
      end
    end
  end

  // Frame memories are BRAM-style: no reset on contents.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      if (front_sel_q) mem0_q[wr_addr] <= wr_data;
      else             mem1_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= i_ren;
      if (i_ren) begin
        if (!raddr_ok)        rdata_q <= '0;
        else if (front_sel_q) rdata_q <= mem1_q[rd_idx];
        else                  rdata_q <= mem0_q[rd_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      front_sel_q  <= 1'b0;
      swap_done_q  <= 1'b0;
      clear_busy_q <= 1'b0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      swap_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_clear) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            clear_busy_q <= 1'b1;
            pending_q    <= i_swap_req;
          end else if (i_swap_req) begin
            if (!i_rd_busy) begin
              front_sel_q <= ~front_sel_q;
              swap_done_q <= 1'b1;
            end else begin
              state_q <= ST_SWAP_WAIT;
            end
          end
        end
        ST_CLEAR: begin
          if (cnt_q == c_last) begin
            clear_busy_q <= 1'b0;
            pending_q    <= 1'b0;
            state_q      <= (pending_q || i_swap_req) ? ST_SWAP_WAIT : ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (i_swap_req) pending_q <= 1'b1;
          end
        end
        ST_SWAP_WAIT: begin
          if (!i_rd_busy) begin
            front_sel_q <= ~front_sel_q;
            swap_done_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rdata      = rdata_q;
  assign o_rvalid     = rvalid_q;
  assign o_swap_done  = swap_done_q;
  assign o_front_sel  = front_sel_q;
  assign o_clear_busy = clear_busy_q;

endmodule
